// File: rtl/arm_mc_pkg.sv
// Shared types for the multicycle ARM control FSM: states, opcodes,
// ALU control codes and condition codes.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef enum logic [3:0] {
    CND_EQ = 4'h0, CND_NE = 4'h1,
    CND_CS = 4'h2, CND_CC = 4'h3,
    CND_MI = 4'h4, CND_PL = 4'h5,
    CND_VS = 4'h6, CND_VC = 4'h7,
    CND_HI = 4'h8, CND_LS = 4'h9,
    CND_GE = 4'hA, CND_LT = 4'hB,
    CND_GT = 4'hC, CND_LE = 4'hD,
    CND_AL = 4'hE, CND_NV = 4'hF
  } cond_e;

  function automatic logic [1:0] alu_dec(
    input logic [3:0] cmd
  );
    unique case (cmd)
      CMD_ADD: alu_dec = ALU_ADD;
      CMD_SUB: alu_dec = ALU_SUB;
      CMD_AND: alu_dec = ALU_AND;
      CMD_ORR: alu_dec = ALU_ORR;
      default: alu_dec = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Link between the control FSM (master) and the
// condition/flag unit (slave).
interface mc_control_fsm_if;
  logic [3:0] cond;
  logic [1:0] flag_w;
  logic [3:0] alu_flags;
  logic       cond_ex;

  modport master (
    output cond, flag_w, alu_flags,
    input  cond_ex
  );

  modport slave (
    input  cond, flag_w, alu_flags,
    output cond_ex
  );
endinterface

// File: rtl/mc_cond_logic.sv
// Stored NZCV register, flag-write gating and
// condition evaluation against the stored flags.
module mc_cond_logic
  import arm_mc_pkg::*;
(
  input logic           clk,
  input logic           reset,
  mc_control_fsm_if.slave cif
);

  logic [3:0] flags_q, flags_d;
  logic       n, z, c, v;
  logic       cond_ex;

  assign n = flags_q[3];
  assign z = flags_q[2];
  assign c = flags_q[1];
  assign v = flags_q[0];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cif.cond)
      CND_EQ: cond_ex = z;
      CND_NE: cond_ex = !z;
      CND_CS: cond_ex = c;
      CND_CC: cond_ex = !c;
      CND_MI: cond_ex = n;
      CND_PL: cond_ex = !n;
      CND_VS: cond_ex = v;
      CND_VC: cond_ex = !v;
      CND_HI: cond_ex = c && !z;
      CND_LS: cond_ex = !c || z;
      CND_GE: cond_ex = (n == v);
      CND_LT: cond_ex = (n != v);
      CND_GT: cond_ex = !z && (n == v);
      CND_LE: cond_ex = z || (n != v);
      CND_AL: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign cif.cond_ex = cond_ex;

  always_comb begin
    flags_d = flags_q;
    if (cif.flag_w[1] && cond_ex)
      flags_d[3:2] = cif.alu_flags[3:2];
    if (cif.flag_w[0] && cond_ex)
      flags_d[1:0] = cif.alu_flags[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle ARM control FSM. Optional retired-instruction
// counter enabled by defining MC_CTRL_PERF_EN.
module mc_control_fsm
  import arm_mc_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] instr_count
`endif
);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       cond_ex;
  logic       is_exec;
  logic       addsub;
  logic       rd_pc;
  state_e     state_q, state_d;
  state_e     st;

  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign rd_pc = (rd == 4'hF);

  logic unused_instr;
  assign unused_instr = ^{Instr[19:16], Instr[11:0]};

  mc_control_fsm_if cif ();

  assign is_exec = (state_q == S_EXECR) || (state_q == S_EXECI);
  assign addsub  = (funct[4:1] == CMD_ADD) || (funct[4:1] == CMD_SUB);

  assign cif.cond      = Instr[31:28];
  assign cif.alu_flags = ALUFlags;
  assign cif.flag_w    = {is_exec && funct[0],
                          is_exec && funct[0] && addsub};
  assign cond_ex       = cif.cond_ex;

  mc_cond_logic u_cond (
    .clk   (clk),
    .reset (reset),
    .cif   (cif)
  );

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      S_MEMWB, S_MEMWR,
      S_ALUWB, S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Reset shows FETCH selects, but every write enable is held low.
  assign st = reset ? S_FETCH : state_q;

  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = op;
    RegSrc     = {op == OP_MEM, op == OP_BR};
    unique case (st)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = !reset;
        PCWrite   = !reset;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex && rd_pc;
      end
      S_EXECR: ALUControl = alu_dec(funct[4:1]);
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(funct[4:1]);
      end
      S_ALUWB: begin
        RegWrite = cond_ex;
        PCWrite  = cond_ex && rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  logic [PERF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q != S_FETCH && state_d == S_FETCH)
      cnt_d = cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`else
  logic [PERF_W-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule
